root_process_inverse: RTL and testbench

Pipelined inverse of the RootProcess datapath: given a stream of (XOUT, B) pairs, reconstructs A = (XOUT + (K·B mod 2^NX) + TEMP) mod 2^NX, so that RootProcess(A, B) reproduces XOUT. It sits on the return path of a RootProcess link as the decoding end. It exchanges data with valid/ready handshakes on both sides and buffers results in a small output FIFO, so downstream backpressure never stalls the arithmetic pipeline.

---
 rtl/root_process_pkg.sv | 11 +
 rtl/rp_sync_fifo.sv | 55 +++++
 rtl/root_process_inverse.sv | 106 ++++++++++
 tb/tb_root_process_inverse.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/root_process_pkg.sv
// Shared constants and the result record for the RootProcess inverse datapath.
package root_process_pkg;
    localparam int RP_K    = 3;
    localparam int RP_TEMP = 21;
    localparam int RP_NX   = 8;

    typedef struct packed {
        logic              wrap;
        logic [RP_NX-1:0]  a;
    } rp_result_t;
endpackage

// File: rtl/rp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; sync active-high reset.
module rp_sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic [W-1:0]               wr_data_i,
    input  logic                       rd_en_i,
    output logic [W-1:0]               rd_data_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q;
    logic          full, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o   = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = rd_en_i && !empty_o;
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // Storage carries no reset: empty/count gate everything that reads it.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)     rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({wr_en_i, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) wr_en_i |-> !full);
endmodule

// File: rtl/root_process_inverse.sv
// Pipelined RootProcess inverse: A = XOUT + (K*B mod 2^NX) + TEMP, credit-flow into an output FIFO.
// Optional statistics counters: define ROOT_PROCESS_INV_STATS_EN.
module root_process_inverse
    import root_process_pkg::*;
#(
    parameter int NX    = RP_NX,
    parameter int K     = RP_K,
    parameter int TEMP  = RP_TEMP,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [NX-1:0] XOUT_IN,
    input  logic [NX-1:0] B_IN,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [NX-1:0] A_OUT,
    output logic          WRAP
`ifdef ROOT_PROCESS_INV_STATS_EN
    ,
    output logic [31:0]   XFER_COUNT,
    output logic [31:0]   WRAP_COUNT
`endif
);
    // Width-parameterised twin of rp_result_t.
    typedef struct packed {
        logic          wrap;
        logic [NX-1:0] a;
    } res_t;

    localparam int CW = $clog2(DEPTH+1);
    localparam int OW = $clog2(DEPTH+3) + 1;

    logic          s1_v_q, s2_v_q;
    logic [NX-1:0] s1_x_q, s1_p_q;
    res_t          s2_q, head;
    logic [NX+1:0] sum;
    logic [CW-1:0] fifo_count;
    logic [OW-1:0] occ;
    logic          fifo_empty, accept;

    assign sum    = {2'b00, s1_x_q} + {2'b00, s1_p_q} + (NX+2)'(TEMP);
    assign accept = IN_VALID && IN_READY;

    // Every accepted pair holds a credit until it leaves the FIFO, so the
    // FIFO can always absorb S2 and the pipeline never needs to stall.
    assign occ      = OW'(s1_v_q) + OW'(s2_v_q) + OW'(fifo_count);
    assign IN_READY = (occ < OW'(DEPTH));

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v_q <= 1'b0;
            s1_x_q <= '0;
            s1_p_q <= '0;
            s2_v_q <= 1'b0;
            s2_q   <= '0;
        end else begin
            s1_v_q <= accept;
            if (accept) begin
                s1_x_q <= XOUT_IN;
                s1_p_q <= B_IN * NX'(K);
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_q.a    <= sum[NX-1:0];
                s2_q.wrap <= |sum[NX+1:NX];
            end
        end
    end

    rp_sync_fifo #(.W($bits(res_t)), .DEPTH(DEPTH)) u_fifo (
        .clk_i     (CLK),
        .rst_i     (RST),
        .wr_en_i   (s2_v_q),
        .wr_data_i (s2_q),
        .rd_en_i   (OUT_READY),
        .rd_data_o (head),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    assign OUT_VALID = !fifo_empty;
    assign A_OUT     = fifo_empty ? '0 : head.a;
    assign WRAP      = fifo_empty ? 1'b0 : head.wrap;

`ifdef ROOT_PROCESS_INV_STATS_EN
    logic [31:0] xfer_q, wrapc_q;
    logic        xfer;

    assign xfer       = OUT_VALID && OUT_READY;
    assign XFER_COUNT = xfer_q;
    assign WRAP_COUNT = wrapc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            xfer_q  <= '0;
            wrapc_q <= '0;
        end else if (xfer) begin
            if (xfer_q != '1)          xfer_q  <= xfer_q + 1'b1;
            if (WRAP && wrapc_q != '1) wrapc_q <= wrapc_q + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_root_process_inverse.sv
// Randomised + directed bench for root_process_inverse against an arithmetic/queue model.
module tb_root_process_inverse;
    import root_process_pkg::*;

    localparam int NX = 8, K = 3, TEMP = 21, DEPTH = 4;

    logic          CLK = 1'b0;
    logic          RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY, WRAP;
    logic [NX-1:0] XOUT_IN, B_IN, A_OUT;
`ifdef ROOT_PROCESS_INV_STATS_EN
    logic [31:0]   XFER_COUNT, WRAP_COUNT;
`endif

    root_process_inverse #(.NX(NX), .K(K), .TEMP(TEMP), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .XOUT_IN(XOUT_IN), .B_IN(B_IN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .A_OUT(A_OUT), .WRAP(WRAP)
`ifdef ROOT_PROCESS_INV_STATS_EN
        , .XFER_COUNT(XFER_COUNT), .WRAP_COUNT(WRAP_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct { int e; rp_result_t r; } item_t;

    item_t       q[$];
    logic [7:0]  rt_q[$];
    int          total = 0, bad = 0, cyc = 0, npops = 0;
    bit          rt_mode = 0, rnd_rdy = 0;
    logic [31:0] mxfer = 0, mwrap = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Forward RootProcess and its inverse, straight from the arithmetic definition.
    function automatic rp_result_t inv(input logic [7:0] x, input logic [7:0] b);
        int s;
        rp_result_t r;
        s = int'(x) + ((K * int'(b)) % 256) + TEMP;
        r.a = 8'(s % 256);
        r.wrap = (s >= 256);
        return r;
    endfunction

    function automatic logic [7:0] fwd(input logic [7:0] a, input logic [7:0] b);
        int t;
        t = int'(a) - ((K * int'(b)) % 256) - TEMP;
        return 8'(((t % 256) + 256) % 256);
    endfunction

    always @(posedge CLK) cyc = cyc + 1;

    // Scoreboard: occupancy, latency, order, values and counters, every cycle.
    always @(negedge CLK) begin
        if (RST) begin
            q.delete();
            mxfer = 0;
            mwrap = 0;
        end else begin
            chk("in_ready", IN_READY, q.size() < DEPTH);
            chk("out_valid", OUT_VALID, q.size() > 0 && cyc >= q[0].e + 2);
`ifdef ROOT_PROCESS_INV_STATS_EN
            chk("xfer_count", XFER_COUNT, mxfer);
            chk("wrap_count", WRAP_COUNT, mwrap);
`endif
            if (OUT_VALID && q.size() > 0) begin
                chk("a_out", A_OUT, q[0].r.a);
                chk("wrap", WRAP, q[0].r.wrap);
            end
            if (OUT_VALID && OUT_READY && q.size() > 0) begin
                if (rt_mode) begin
                    if (rt_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL rt_extra: unexpected output %0h", A_OUT);
                    end else chk("rt_a", A_OUT, rt_q.pop_front());
                end
                if (mxfer != 32'hFFFF_FFFF) mxfer++;
                if (q[0].r.wrap && mwrap != 32'hFFFF_FFFF) mwrap++;
                void'(q.pop_front());
                npops++;
            end
            if (IN_VALID && IN_READY) q.push_back('{e: cyc + 1, r: inv(XOUT_IN, B_IN)});
        end
    end

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] b);
        int n = 0;
        IN_VALID = 1'b1; XOUT_IN = x; B_IN = b;
        do begin
            if (rnd_rdy) OUT_READY = ($urandom_range(0, 3) != 0);
            @(negedge CLK);
            n++;
        end while (!IN_READY && n < 50);
        if (!IN_READY) begin
            chk("send_timeout", 32'(IN_READY), 32'd1);
            IN_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    // Single pair from idle with OUT_READY high: valid appears only after edge t+2.
    task automatic dir(input string nm, input logic [7:0] x, input logic [7:0] b,
                       input logic [7:0] ea, input logic ew);
        OUT_READY = 1'b1;
        send(x, b);
        @(negedge CLK); chk({nm, "_v_t0"}, OUT_VALID, 0);
        @(negedge CLK); chk({nm, "_v_t1"}, OUT_VALID, 0);
        @(negedge CLK); chk({nm, "_v_t2"}, OUT_VALID, 1);
        chk({nm, "_a"}, A_OUT, ea);
        chk({nm, "_wrap"}, WRAP, ew);
        idle(3);
    endtask

    initial begin
        logic [7:0] bx[6], bb[6];
        logic [7:0] a, b;
        int idx, p0;
        bit acc;

        RST = 1'b1; IN_VALID = 1'b0; XOUT_IN = '0; B_IN = '0; OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        @(negedge CLK);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_a_out", A_OUT, 0);
        chk("rst_wrap", WRAP, 0);
`ifdef ROOT_PROCESS_INV_STATS_EN
        chk("rst_xfer", XFER_COUNT, 0);
        chk("rst_wrapc", WRAP_COUNT, 0);
`endif
        @(posedge CLK); #1;

        chk("model_basic", 32'(inv(8'h10, 8'h02)), 32'h02B);
        chk("model_wrap", 32'(inv(8'hF0, 8'h20)), 32'h165);
        chk("model_trunc", 32'(inv(8'h00, 8'h60)), 32'h035);

        dir("basic", 8'h10, 8'h02, 8'h2B, 1'b0);
        dir("wrapv", 8'hF0, 8'h20, 8'h65, 1'b1);
`ifdef ROOT_PROCESS_INV_STATS_EN
        chk("wrap_count_1", WRAP_COUNT, 1);
`endif
        dir("trunc", 8'h00, 8'h60, 8'h35, 1'b0);

        // Backpressure: 6 offered with OUT_READY low; only DEPTH get in.
        for (int i = 0; i < 6; i++) begin
            bx[i] = 8'($urandom);
            bb[i] = 8'($urandom);
        end
        p0 = npops;
        OUT_READY = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            IN_VALID = (idx < 6);
            XOUT_IN = bx[idx % 6]; B_IN = bb[idx % 6];
            @(negedge CLK);
            acc = IN_VALID && IN_READY;
            @(posedge CLK); #1;
            if (acc) idx++;
        end
        IN_VALID = 1'b0;
        chk("bp_accepted", idx, 4);
        @(negedge CLK);
        chk("bp_in_ready", IN_READY, 0);
        chk("bp_hold_valid", OUT_VALID, 1);
        @(posedge CLK); #1;
        OUT_READY = 1'b1;
        while (idx < 6) begin
            send(bx[idx], bb[idx]);
            idx++;
        end
        idle(10);
        chk("bp_pops", npops - p0, 6);

        // Reset with three entries in flight.
        send(8'h11, 8'h22);
        send(8'h33, 8'h44);
        send(8'h55, 8'h66);
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        p0 = npops;
        @(negedge CLK);
        chk("midrst_out_valid", OUT_VALID, 0);
        chk("midrst_in_ready", IN_READY, 1);
`ifdef ROOT_PROCESS_INV_STATS_EN
        chk("midrst_xfer", XFER_COUNT, 0);
`endif
        @(posedge CLK); #1;
        idle(8);
        chk("midrst_no_stale", npops - p0, 0);

        // Round trip through the forward model with random backpressure and gaps.
        p0 = npops;
        rt_mode = 1'b1;
        rnd_rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            send(fwd(a, b), b);
            rt_q.push_back(a);
            if ($urandom_range(0, 3) == 0) begin
                OUT_READY = ($urandom_range(0, 1) != 0);
                idle(1);
            end
        end
        rnd_rdy = 1'b0;
        OUT_READY = 1'b1;
        idle(12);
        chk("rt_pops", npops - p0, 256);
        chk("rt_leftover", rt_q.size(), 0);
`ifdef ROOT_PROCESS_INV_STATS_EN
        chk("rt_xfer_count", XFER_COUNT, 256);
`endif
        rt_mode = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
